settings_bus_mux_rr: RTL
========================

Name: settings_bus_mux_rr

Overview:
Parametrised successor to the plain settings bus mux. It merges NUM_BUSES per-channel settings buses onto one shared settings bus for resources shared between radio channels, such as the timekeeper. Each input bus gets its own buffer. Non-empty buffers are drained under fair round-robin arbitration with downstream backpressure. Dropped writes are flagged per bus, and the output reports which bus each write came from.

Parameters:
- AWIDTH, 8, settings address width.
- DWIDTH, 32, settings data width.
- NUM_BUSES, 2, number of input buses; must be >= 1.
- FIFO_SIZE, 3, log2 of per-bus buffer depth; must be >= 1 (depth = 2**FIFO_SIZE).
- SRCW, $clog2(NUM_BUSES) or 1 when NUM_BUSES=1, width of out_src.

Ports:
- clk, input, 1, block clock.
- reset, input, 1, asynchronous active-high reset.
- clear, input, 1, synchronous flush.
- in_set_stb, input, NUM_BUSES, per-bus write strobe.
- in_set_addr, input, NUM_BUSES*AWIDTH, per-bus address; bus i occupies bits [AWIDTH*i+AWIDTH-1 : AWIDTH*i].
- in_set_data, input, NUM_BUSES*DWIDTH, per-bus data; packed the same way.
- out_set_stb, output, 1, merged write strobe.
- out_set_addr, output, AWIDTH, merged address.
- out_set_data, output, DWIDTH, merged data.
- out_src, output, SRCW, index of the bus that sourced the current out_set_stb.
- ready, input, 1, downstream may accept a write this cycle.
- overflow, output, NUM_BUSES, sticky per-bus drop flag.
- drop_cnt, output, NUM_BUSES*16, per-bus drop counters (see Optional Feature).

Behaviour:
- Reset (async, active-high): all buffers empty; overflow=0; out_set_stb=0; out_set_addr=0; out_set_data=0; out_src=0; round-robin pointer = NUM_BUSES-1, so the first search starts at bus 0.
- Push: in_set_stb[i]=1 writes {addr,data} into buffer i when it is not full.
  - Full and no pop on bus i this cycle: write dropped, overflow[i] set.
  - Full with a pop on bus i the same cycle: write accepted, no drop.
- Arbitration, each cycle with ready=1:
  - Search starts at pointer+1 mod NUM_BUSES and wraps; the first non-empty buffer wins.
  - Winner's head is popped; pointer <= winner.
  - Next cycle: out_set_stb=1, out_set_addr/out_set_data = popped entry, out_src = winner.
- ready=0: no pop; next cycle out_set_stb=0; pointer unchanged.
- Output registers hold their last values while out_set_stb=0. out_set_stb is a single-cycle pulse per popped entry.
- Throughput: one write per cycle while ready=1 and any buffer is non-empty.
- Latency: push at cycle N gives earliest out_set_stb at cycle N+2 (buffer write at N, head visible at N+1, output register at N+2).
- Order: entries from one bus leave in arrival order. Between buses there is no order guarantee beyond round-robin.
- Fairness: with k buses continuously non-empty, each bus is granted exactly once per k grants.
- clear=1 (synchronous, highest priority over push and pop):
  - Flushes all buffers; overflow=0; pointer=NUM_BUSES-1; next-cycle out_set_stb=0.
  - Strobes arriving in the same cycle are discarded and do not count as drops.
- NUM_BUSES=1: degenerates to a single buffer with registered output; out_src=0 always.
- Reset asserted mid-burst: outputs return to reset values immediately (asynchronous); queued entries are lost.

Optional Feature:
- Macro: SETTINGS_BUS_MUX_DROP_CNT_EN.
- Defined: per-bus 16-bit drop counter.
  - Increments on each dropped write and saturates at 16'hFFFF.
  - Cleared by reset and by clear.
  - Exposed on drop_cnt; bus i occupies bits [16*i+15 : 16*i].
- Not defined: drop_cnt is tied to 0 and no counter flops are inferred. overflow behaves the same in both cases.

Decomposition:
- Package settings_bus_mux_pkg:
  - entry-width constant (AWIDTH+DWIDTH).
  - clog2-with-minimum-1 function used for SRCW.
  - round-robin next-index function.
  - counter width constant DROP_CNT_W=16.
- Sub-module sbmux_fifo:
  - Single-clock buffer, depth 2**FIFO_SIZE, first-word-fall-through head.
  - Ports: full, empty, push, pop, clear.
  - Instantiated once per bus in a generate loop.
- Arbiter and output register live in the top module.

Test Plan:
- Single write, NUM_BUSES=2, ready=1: bus 1 writes addr 8'h10, data 32'hDEAD_BEEF at cycle 5 -> out_set_stb only at cycle 7 with addr 8'h10, data 32'hDEAD_BEEF, out_src=1.
- Round-robin, NUM_BUSES=4, ready=1: each bus pre-loaded with 3 writes, data = {bus, seq} -> output order bus0..bus3 repeated 3 times; 12 consecutive strobes; per-bus seq ascending.
- Backpressure: bus0 loaded with 4 writes; ready=0 for 10 cycles, then ready=1 -> no strobe while ready=0; then 4 consecutive strobes in order; overflow=0.
- Overflow, FIFO_SIZE=2, ready=0: 6 writes on bus 2 -> overflow=4'b0100; after ready=1 only the first 4 entries emerge; drop_cnt bus 2 = 2 with macro, 0 without.
- Full with simultaneous push/pop, FIFO_SIZE=1, ready=1: bus0 full (2 entries) receives a push in the cycle its head pops -> push accepted, overflow[0]=0, 3 strobes total.
- Clear and reset: 3 queued writes on bus 1, clear pulsed -> no strobes, overflow=0, next grant searches from bus 0. Reset asserted mid-burst -> out_set_stb falls in the same cycle (asynchronously); all outputs 0.

Source files
------------

// File: rtl/settings_bus_mux_pkg.sv
// Shared helpers for the round-robin settings bus mux.
package settings_bus_mux_pkg;

  // Width of one drop counter lane on drop_cnt.
  localparam int DROP_CNT_W = 16;

  // One buffered entry is {addr, data}.
  function automatic int entry_width(input int aw, input int dw);
    return aw + dw;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Next index in a ring of n slots.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sbmux_fifo.sv
// Per-bus buffer for settings_bus_mux_rr: single clock, depth 2**FIFO_SIZE,
// first-word-fall-through head. Push while full is accepted only with a pop.
module sbmux_fifo #(
  parameter int WIDTH     = 40,
  parameter int FIFO_SIZE = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 2 ** FIFO_SIZE;
  localparam int PTR_W = FIFO_SIZE + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Storage holds data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[wr_ptr[FIFO_SIZE-1:0]] <= din;
  end

  // Pointer bookkeeping; the extra MSB separates full from empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  assign dout  = mem[rd_ptr[FIFO_SIZE-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[FIFO_SIZE] != rd_ptr[FIFO_SIZE]) &&
                 (wr_ptr[FIFO_SIZE-1:0] == rd_ptr[FIFO_SIZE-1:0]);

endmodule

// File: rtl/settings_bus_mux_rr.sv
// Merges NUM_BUSES settings buses onto one shared bus. Each bus has its own
// buffer; buffers are drained round-robin under downstream backpressure.
// Optional macro SETTINGS_BUS_MUX_DROP_CNT_EN adds saturating per-bus drop
// counters on drop_cnt; without it drop_cnt is constant zero.
module settings_bus_mux_rr
  import settings_bus_mux_pkg::*;
#(
  parameter int AWIDTH    = 8,
  parameter int DWIDTH    = 32,
  parameter int NUM_BUSES = 2,
  parameter int FIFO_SIZE = 3,
  parameter int SRCW      = clog2_min1(NUM_BUSES)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clear,
  input  logic [NUM_BUSES-1:0]            in_set_stb,
  input  logic [NUM_BUSES*AWIDTH-1:0]     in_set_addr,
  input  logic [NUM_BUSES*DWIDTH-1:0]     in_set_data,
  output logic                            out_set_stb,
  output logic [AWIDTH-1:0]               out_set_addr,
  output logic [DWIDTH-1:0]               out_set_data,
  output logic [SRCW-1:0]                 out_src,
  input  logic                            ready,
  output logic [NUM_BUSES-1:0]            overflow,
  output logic [NUM_BUSES*DROP_CNT_W-1:0] drop_cnt
);

  localparam int ENTRY_W = entry_width(AWIDTH, DWIDTH);

  logic [NUM_BUSES-1:0] fifo_full, fifo_empty, push, pop, drop;
  logic [ENTRY_W-1:0]   head [NUM_BUSES];
  logic [SRCW-1:0]      rr_ptr, grant_idx, scan_idx;
  logic                 grant_vld;

  // ---- stage p0: per-bus buffering, accept/drop decision ----
  for (genvar i = 0; i < NUM_BUSES; i++) begin : g_bus
    assign pop[i]  = ready && grant_vld && !clear && (grant_idx == SRCW'(i));
    assign push[i] = in_set_stb[i] && !clear && (!fifo_full[i] || pop[i]);
    assign drop[i] = in_set_stb[i] && !clear && fifo_full[i] && !pop[i];

    sbmux_fifo #(
      .WIDTH     (ENTRY_W),
      .FIFO_SIZE (FIFO_SIZE)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   ({in_set_addr[AWIDTH*i +: AWIDTH], in_set_data[DWIDTH*i +: DWIDTH]}),
      .dout  (head[i]),
      .full  (fifo_full[i]),
      .empty (fifo_empty[i])
    );
  end

  // Round-robin search from the slot after the last winner; first non-empty wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = SRCW'(rr_next(int'(rr_ptr), NUM_BUSES));
    for (int k = 0; k < NUM_BUSES; k++) begin
      if (!grant_vld && !fifo_empty[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
      scan_idx = SRCW'(rr_next(int'(scan_idx), NUM_BUSES));
    end
  end

  // ---- stage p1: registered merged output ----
  // Popped entry appears next cycle as a one-cycle strobe; data holds otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_set_stb  <= 1'b0;
      out_set_addr <= '0;
      out_set_data <= '0;
      out_src      <= '0;
      rr_ptr       <= SRCW'(NUM_BUSES - 1);
    end else if (clear) begin
      out_set_stb  <= 1'b0;
      rr_ptr       <= SRCW'(NUM_BUSES - 1);
    end else begin
      out_set_stb <= |pop;
      if (|pop) begin
        {out_set_addr, out_set_data} <= head[grant_idx];
        out_src <= grant_idx;
        rr_ptr  <= grant_idx;
      end
    end
  end

  // Sticky per-bus drop flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      overflow <= '0;
    else if (clear) overflow <= '0;
    else            overflow <= overflow | drop;
  end

`ifdef SETTINGS_BUS_MUX_DROP_CNT_EN
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

  for (genvar i = 0; i < NUM_BUSES; i++) begin : g_drop_cnt
    logic [DROP_CNT_W-1:0] cnt;
    // Saturating count of dropped writes on this bus.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)        cnt <= '0;
      else if (clear)   cnt <= '0;
      else if (drop[i]) cnt <= sat_inc(cnt);
    end
    assign drop_cnt[DROP_CNT_W*i +: DROP_CNT_W] = cnt;
  end
`else
  assign drop_cnt = '0;
`endif

endmodule
